// File: rtl/mul8_seq_pkg.sv
// Shared definitions for the sequential 8x8 multiplier: FSM state encoding
// and iteration count.
package mul8_seq_pkg;

  // One partial-product add per multiplier bit.
  localparam int MUL_ITERS = 8;

  // Counter value during the final iteration (cnt never holds MUL_ITERS in RUN).
  localparam logic [3:0] MUL_CNT_LAST = 4'(MUL_ITERS - 1);

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage : mul8_seq_pkg

// File: rtl/mul8_seq_add8.sv
// 8-bit ripple-carry adder (add8), shared by the math datapath.
module add8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] carry;

  // Ripple the carry through eight full-adder stages.
  always_comb begin
    // NOTE: every combinationally driven signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < 8; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[8];

endmodule : add8

// File: rtl/mul8_seq.sv
// Sequential 8x8 unsigned shift-add multiplier. One add8 is reused for one
// partial-product add per cycle; start/busy/done handshake, registered product.
module mul8_seq
  import mul8_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  mul_state_e state;
  mul_state_e state_next;

  logic [7:0] mcand;   // captured multiplicand
  logic [7:0] mq;      // multiplier, shifted out LSB first; fills with product low bits
  logic [7:0] acc;     // running partial sum, high half of the product
  logic [3:0] cnt;     // iterations completed in the current operation

  logic       load;    // accept a new operation this edge
  logic       step;    // perform one shift-add iteration this edge
  logic       last;    // this iteration is the final one

  logic [7:0] addend;
  logic [7:0] add_sum;
  logic       add_cout;

  // Add the multiplicand only when the current multiplier bit is set.
  assign addend = mq[0] ? mcand : 8'h00;

  add8 u_add (
    .a    (acc),
    .b    (addend),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Next-state and datapath control; start is only honoured in IDLE and DONE.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    unique case (state)
      MUL_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = MUL_RUN;
        end
      end
      MUL_RUN: begin
        step = 1'b1;
        if (cnt == MUL_CNT_LAST) begin
          last       = 1'b1;
          state_next = MUL_DONE;
        end
      end
      MUL_DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = MUL_RUN;
        end else begin
          state_next = MUL_IDLE;
        end
      end
      default: state_next = MUL_IDLE;
    endcase
  end

  // State register and shift datapath; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state   <= MUL_IDLE;
      mcand   <= 8'h00;
      mq      <= 8'h00;
      acc     <= 8'h00;
      cnt     <= 4'd0;
      product <= 16'h0000;
    end else begin
      state <= state_next;
      if (load) begin
        mcand <= a;
        mq    <= b;
        acc   <= 8'h00;
        cnt   <= 4'd0;
      end else if (step) begin
        // 17-bit right shift of {cout, sum, mq}: cout lands in acc[7].
        acc <= {add_cout, add_sum[7:1]};
        mq  <= {add_sum[0], mq[7:1]};
        cnt <= cnt + 4'd1;
        if (last) begin
          product <= {add_cout, add_sum, mq[7:1]};
        end
      end
    end
  end

  assign busy = (state == MUL_RUN);
  assign done = (state == MUL_DONE);

endmodule : mul8_seq

// File: tb/tb_mul8_seq.sv
// Self-checking bench for mul8_seq: directed scenarios plus a randomized
// sweep compared against plain a*b arithmetic.
module tb_mul8_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int tests_run    = 0;
  int tests_failed = 0;

  mul8_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  // Launch one operation and wait (bounded) for done. edges counts rising
  // edges from the accepting edge (inclusive) to the one that raises done.
  // Operands are scrambled after acceptance to prove they were captured.
  task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b,
                        output int edges, output int busy_cycles,
                        output logic [15:0] prod);
    @(negedge clk);
    a     = op_a;
    b     = op_b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    a           = 8'($urandom);
    b           = 8'($urandom);
    edges       = 1;
    busy_cycles = busy ? 1 : 0;
    while (!done && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
      if (busy) busy_cycles++;
    end
    prod = product;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (product !== 16'h0000) begin
      $display("FAIL reset_product: got %h expected 0000", product);
      tests_failed++;
    end
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL reset_flags: got busy=%b done=%b expected 0 0", busy, done);
      tests_failed++;
    end
  endtask

  task automatic test_zero();
    int edges, bc;
    logic [15:0] p;
    run_op(8'h00, 8'h00, edges, bc, p);
    tests_run++;
    if (edges !== 9) begin
      $display("FAIL zero_latency: got %0d edges expected 9", edges);
      tests_failed++;
    end
    tests_run++;
    if (p !== 16'h0000) begin
      $display("FAIL zero_product: got %h expected 0000", p);
      tests_failed++;
    end
  endtask

  task automatic test_max();
    int edges, bc;
    logic [15:0] p;
    run_op(8'hFF, 8'hFF, edges, bc, p);
    tests_run++;
    if (p !== 16'hFE01 || edges !== 9) begin
      $display("FAIL max_product: got %h after %0d edges expected fe01 after 9", p, edges);
      tests_failed++;
    end
    tests_run++;
    if (bc !== 8) begin
      $display("FAIL max_busy_cycles: got %0d expected 8", bc);
      tests_failed++;
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL max_done_pulse: got done=%b busy=%b expected 0 0", done, busy);
      tests_failed++;
    end
    repeat (5) @(posedge clk);
    #1;
    tests_run++;
    if (product !== 16'hFE01) begin
      $display("FAIL max_hold: got %h expected fe01", product);
      tests_failed++;
    end
  endtask

  task automatic test_ignore_start();
    int edges;
    int extra_done;
    @(negedge clk);
    a     = 8'h0F;
    b     = 8'h11;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 1;
    repeat (2) begin
      @(posedge clk);
      edges++;
    end
    @(negedge clk);
    a     = 8'h01;
    b     = 8'h01;
    start = 1'b1;
    repeat (3) begin
      @(posedge clk);
      edges++;
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    while (!done && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    tests_run++;
    if (product !== 16'h00FF || edges !== 9) begin
      $display("FAIL ignore_product: got %h after %0d edges expected 00ff after 9", product, edges);
      tests_failed++;
    end
    extra_done = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) extra_done++;
    end
    tests_run++;
    if (extra_done !== 0 || product !== 16'h00FF) begin
      $display("FAIL ignore_no_extra: got %0d extra done, product %h expected 0, 00ff", extra_done, product);
      tests_failed++;
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    @(negedge clk);
    a     = 8'h55;
    b     = 8'hAA;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 1;
    while (!done && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    tests_run++;
    if (product !== 16'h3872 || edges !== 9) begin
      $display("FAIL b2b_first: got %h after %0d edges expected 3872 after 9", product, edges);
      tests_failed++;
    end
    // Still inside the DONE cycle: request the next operation.
    a     = 8'h02;
    b     = 8'h03;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 1;
    tests_run++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      $display("FAIL b2b_accept: got busy=%b done=%b expected 1 0", busy, done);
      tests_failed++;
    end
    while (!done && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    tests_run++;
    if (product !== 16'h0006 || edges !== 9) begin
      $display("FAIL b2b_second: got %h after %0d edges expected 0006 after 9", product, edges);
      tests_failed++;
    end
  endtask

  task automatic test_reset_mid_op();
    int done_seen;
    @(negedge clk);
    a     = 8'hFF;
    b     = 8'h02;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      $display("FAIL midrst_state: got busy=%b done=%b product=%h expected 0 0 0000", busy, done, product);
      tests_failed++;
    end
    rst = 1'b0;
    done_seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    tests_run++;
    if (done_seen !== 0 || product !== 16'h0000) begin
      $display("FAIL midrst_no_done: got %0d done pulses, product %h expected 0, 0000", done_seen, product);
      tests_failed++;
    end
  endtask

  // Check one operation against the arithmetic reference.
  task automatic check_op(input logic [7:0] op_a, input logic [7:0] op_b);
    int edges, bc;
    logic [15:0] p;
    logic [15:0] expected;
    expected = 16'(op_a) * 16'(op_b);
    run_op(op_a, op_b, edges, bc, p);
    tests_run++;
    if (p !== expected || edges !== 9) begin
      $display("FAIL sweep %h*%h: got %h after %0d edges expected %h after 9", op_a, op_b, p, edges, expected);
      tests_failed++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      check_op(8'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 256; i++) begin
      check_op(8'(i), 8'h01);
      check_op(8'(i), 8'h80);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_max();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_mul8_seq
